// File: rtl/trace_feeder_if.sv
// Cache-side handshake between the trace feeder and the cache engine.
// Ports: trace_valid/trace_addr offered by the feeder, trace_ready/access_done returned by the cache.
// master = feeder side, slave = cache side.
interface trace_feeder_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  trace_valid;
  logic [ADDR_WIDTH-1:0] trace_addr;
  logic                  trace_ready;
  logic                  access_done;

  modport master (
    output trace_valid,
    output trace_addr,
    input  trace_ready,
    input  access_done
  );

  modport slave (
    input  trace_valid,
    input  trace_addr,
    output trace_ready,
    output access_done
  );
endinterface

// File: rtl/trace_feeder.sv
// Streams a stored trace from block RAM to the cache, one address per resolved access.
// Latency: start -> first trace_valid is RAM_LATENCY+2 cycles; prefetch hides RAM latency behind cache latency.
// Backpressure: trace_addr is held with trace_valid high until trace_ready; nothing advances until access_done.
// Ports: clk/reset (sync, active-high); start/trace_len begin a run; ram_addr/ram_data read the trace RAM;
//   cache (trace_feeder_if.master) carries trace_valid/trace_addr/trace_ready/access_done;
//   busy/done/issued_count/protocol_err report run status.
module trace_feeder #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DEPTH_BITS  = 10,
  parameter int RAM_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DEPTH_BITS:0]   trace_len,
  output logic [DEPTH_BITS-1:0] ram_addr,
  input  logic [ADDR_WIDTH-1:0] ram_data,
  trace_feeder_if.master        cache,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           issued_count,
  output logic                  protocol_err
);

  localparam int LW = $clog2(RAM_LATENCY + 1);
  localparam logic [DEPTH_BITS:0] MAX_LEN = {1'b1, {DEPTH_BITS{1'b0}}};

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, FIN} state_t;

  state_t                state;
  logic [DEPTH_BITS:0]   len_q;
  logic [DEPTH_BITS:0]   rd_cnt;    // entries whose RAM read has been launched
  logic                  rd_busy;   // a RAM read is in flight
  logic [LW-1:0]         lat_cnt;   // cycles since ram_addr of the in-flight read was driven
  logic                  pf_full;
  logic [ADDR_WIDTH-1:0] pf_buf;
  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic                rd_done;
  logic                more_to_read;
  logic                last_resolved;
  logic                can_prefetch;
  logic                consume;
  logic [DEPTH_BITS:0] len_clamped;

  assign cache.trace_valid = valid_q;
  assign cache.trace_addr  = addr_q;

  assign len_clamped   = (trace_len > MAX_LEN) ? MAX_LEN : trace_len;
  assign rd_done       = rd_busy && (lat_cnt == LW'(RAM_LATENCY));
  assign more_to_read  = rd_cnt < len_q;
  // The outstanding access is the last one once every entry has been accepted.
  assign last_resolved = issued_count == 16'(len_q);
  // The next read is launched as soon as the current entry has been captured (already in
  // ISSUE), so its RAM latency overlaps the handshake and the cache access.
  assign can_prefetch  = (state == ISSUE || state == WAIT || state == FETCH) &&
                         more_to_read && !pf_full && !rd_busy;
  // Read data goes straight to trace_addr when the feeder is waiting on it; otherwise it is parked.
  assign consume       = (state == FETCH) || (state == WAIT && cache.access_done);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      len_q        <= '0;
      rd_cnt       <= '0;
      rd_busy      <= 1'b0;
      lat_cnt      <= '0;
      pf_full      <= 1'b0;
      pf_buf       <= '0;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      ram_addr     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      issued_count <= '0;
      protocol_err <= 1'b0;
    end else begin
      done <= 1'b0;

      if (rd_busy) lat_cnt <= lat_cnt + LW'(1);
      if (rd_done) rd_busy <= 1'b0;
      if (rd_done && !consume) begin
        pf_buf  <= ram_data;
        pf_full <= 1'b1;
      end

      if (can_prefetch) begin
        ram_addr <= rd_cnt[DEPTH_BITS-1:0];
        rd_cnt   <= rd_cnt + (DEPTH_BITS+1)'(1);
        rd_busy  <= 1'b1;
        lat_cnt  <= '0;
      end

      if (cache.access_done && (state == IDLE || state == FETCH || state == ISSUE))
        protocol_err <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            if (trace_len == '0) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              len_q        <= len_clamped;
              issued_count <= '0;
              ram_addr     <= '0;
              rd_cnt       <= (DEPTH_BITS+1)'(1);
              rd_busy      <= 1'b1;
              lat_cnt      <= '0;
              busy         <= 1'b1;
              state        <= FETCH;
            end
          end
        end
        FETCH: begin
          if (rd_done) begin
            addr_q  <= ram_data;
            valid_q <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (valid_q && cache.trace_ready) begin
            valid_q      <= 1'b0;
            issued_count <= issued_count + 16'd1;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (cache.access_done) begin
            if (last_resolved) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FIN;
            end else if (pf_full) begin
              addr_q  <= pf_buf;
              pf_full <= 1'b0;
              valid_q <= 1'b1;
              state   <= ISSUE;
            end else if (rd_done) begin
              addr_q  <= ram_data;
              valid_q <= 1'b1;
              state   <= ISSUE;
            end else begin
              // Either a read is still in flight or none was launched yet; FETCH covers both.
              state <= FETCH;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_feeder.sv
// Directed bench for trace_feeder: RAM and cache models, vector table of whole runs, plus corner sequences.
// Latency: checks cycle-exact timing of first valid, prefetch gaps and done pulse.
// Backpressure: exercises trace_ready held low and cache latencies both shorter and longer than the RAM.
module tb_trace_feeder;
  localparam int AW = 16;
  localparam int DB = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DB:0]   trace_len;
  logic [DB-1:0] ram_addr;
  logic [AW-1:0] ram_data;
  logic          busy, done, protocol_err;
  logic [15:0]   issued_count;

  trace_feeder_if #(.ADDR_WIDTH(AW)) cif();

  trace_feeder #(.ADDR_WIDTH(AW), .DEPTH_BITS(DB), .RAM_LATENCY(3)) dut (
    .clk(clk), .reset(reset), .start(start), .trace_len(trace_len),
    .ram_addr(ram_addr), .ram_data(ram_data), .cache(cif),
    .busy(busy), .done(done), .issued_count(issued_count), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Trace RAM: data for the address driven in cycle n is valid in cycle n+3.
  logic [AW-1:0] mem [1024];
  logic [AW-1:0] p1, p2;
  always @(posedge clk) begin
    p1       <= mem[ram_addr];
    p2       <= p1;
    ram_data <= p2;
  end

  typedef struct {
    int len; int lat0; int lat; int rdy_hold;
    int exp_first; int exp_gap; int exp_done; int exp_issued; int exp_stall; int exp_pf0;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int r_first, r_gmin, r_gmax, r_done, r_done_cyc, r_stall, r_hold_bad, r_cnt_bad, r_addr_bad;
  int r_pf0, r_acc, r_busy, r_issued, r_timeout;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Plays one run with a cache that accepts from cycle rdy_hold on and resolves lat cycles after acceptance.
  task automatic run(input int len, input int lat0, input int lat, input int rdy_hold,
                     input int restart_at, input int abort_acc);
    int rel, done_at, last_done, acc_cyc, w_lo, w_hi, g;
    logic prev_valid;
    logic [AW-1:0] held;
    logic [DB-1:0] prev_ram;
    r_timeout = 0; r_first = -1; r_gmin = 1 << 30; r_gmax = -1; r_done = -1; r_done_cyc = 0;
    r_stall = 0; r_hold_bad = 0; r_cnt_bad = 0; r_addr_bad = 0; r_pf0 = 0; r_acc = 0;
    r_busy = 0; r_issued = 0;
    rel = 0; done_at = -1; last_done = -1; acc_cyc = -1; w_lo = -1; w_hi = -1;
    prev_valid = 1'b0; held = '0; prev_ram = ram_addr;
    start = 1'b1; trace_len = (DB+1)'(len);
    cif.trace_ready = (rdy_hold == 0); cif.access_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      rel++;
      start = 1'b0; cif.access_done = 1'b0;
      if (rel > 6000) begin r_timeout = 1; break; end
      if (abort_acc > 0 && r_acc == abort_acc && rel == acc_cyc + 2) begin reset = 1'b1; break; end
      if (issued_count != 16'(r_acc)) r_cnt_bad++;
      if (rel > w_lo && rel <= w_hi && ram_addr != prev_ram) r_pf0++;
      prev_ram = ram_addr;
      if (done) r_done_cyc++;
      if (r_done >= 0) begin r_busy = busy; r_issued = issued_count; break; end
      if (done) r_done = rel;
      if (cif.trace_valid) begin
        if (!prev_valid) begin
          if (r_acc == 0) r_first = rel;
          else begin
            g = rel - last_done;
            if (g < r_gmin) r_gmin = g;
            if (g > r_gmax) r_gmax = g;
          end
          held = cif.trace_addr;
          if (cif.trace_addr != mem[r_acc % 1024]) r_addr_bad++;
        end else if (cif.trace_addr != held) r_hold_bad++;
      end
      prev_valid = cif.trace_valid;
      cif.trace_ready = (rel >= rdy_hold);
      if (restart_at > 0 && rel == restart_at) begin start = 1'b1; trace_len = (DB+1)'(5); end
      if (rel == done_at) begin cif.access_done = 1'b1; last_done = rel; end
      if (cif.trace_valid && !cif.trace_ready) r_stall++;
      if (cif.trace_valid && cif.trace_ready) begin
        if (r_acc == 0) begin w_lo = rel; w_hi = rel + lat0; end
        done_at = rel + ((r_acc == 0) ? lat0 : lat);
        acc_cyc = rel;
        r_acc++;
      end
    end
  endtask

  task automatic check_run(input string tag, input vec_t v);
    chk({tag, " timeout"}, r_timeout, 0);
    chk({tag, " first_valid_cycle"}, r_first, v.exp_first);
    if (v.len > 1) begin
      chk({tag, " min_gap_after_done"}, r_gmin, v.exp_gap);
      chk({tag, " max_gap_after_done"}, r_gmax, v.exp_gap);
    end
    chk({tag, " done_cycle"}, r_done, v.exp_done);
    chk({tag, " done_width"}, r_done_cyc, 1);
    chk({tag, " issued_count"}, r_issued, v.exp_issued);
    chk({tag, " busy_after"}, r_busy, 0);
    chk({tag, " stall_cycles"}, r_stall, v.exp_stall);
    chk({tag, " addr_hold"}, r_hold_bad, 0);
    chk({tag, " issued_tracking"}, r_cnt_bad, 0);
    chk({tag, " addr_sequence"}, r_addr_bad, 0);
    chk({tag, " prefetch_reads_entry0"}, r_pf0, v.exp_pf0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    vec_t pv;
    logic [DB-1:0] prev_ra;
    int nv, nr, nd;

    for (int i = 0; i < 1024; i++) mem[i] = 16'((i * 40503) ^ 16'h3C5A);
    mem[0] = 16'd0; mem[1] = 16'd9; mem[2] = 16'd8; mem[3] = 16'd1;
    mem[4] = 16'h1234; mem[5] = 16'hBEEF; mem[6] = 16'h00FF; mem[7] = 16'hFFFF;

    //            len  lat0 lat rdy  first gap done  issued stall pf0
    tbl[0] = '{   4,   4,  4,  0,    5,  1,   25,    4,   0,  1};
    tbl[1] = '{   4,  68,  4,  0,    5,  1,   89,    4,   0,  1};
    tbl[2] = '{   1,   2,  2,  0,    5,  0,    8,    1,   0,  0};
    tbl[3] = '{   3,   1,  1,  0,    5,  4,   17,    3,   0,  1};
    tbl[4] = '{   8,   6,  6,  0,    5,  1,   61,    8,   0,  1};
    tbl[5] = '{   2,   4,  4, 15,    5,  1,   25,    2,  10,  0};
    tbl[6] = '{2047,   4,  4,  0,    5,  1, 5125, 1024,   0,  1};

    reset = 1'b1; start = 1'b0; trace_len = '0;
    cif.trace_ready = 1'b0; cif.access_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ram_addr", int'(ram_addr), 0);
    chk("reset trace_valid", int'(cif.trace_valid), 0);
    chk("reset trace_addr", int'(cif.trace_addr), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset issued_count", int'(issued_count), 0);
    chk("reset protocol_err", int'(protocol_err), 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run(tbl[i].len, tbl[i].lat0, tbl[i].lat, tbl[i].rdy_hold, 0, 0);
      check_run($sformatf("vec%0d", i), tbl[i]);
    end

    // Zero-length run: immediate done, no RAM activity, issued_count keeps the previous run's value.
    start = 1'b1; trace_len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("len0 done_next_cycle", int'(done), 1);
    chk("len0 busy", int'(busy), 0);
    prev_ra = ram_addr; nv = 0; nr = 0; nd = 0;
    for (int c = 2; c <= 6; c++) begin
      @(posedge clk); #1;
      if (cif.trace_valid) nv++;
      if (ram_addr != prev_ra) nr++;
      if (done) nd++;
    end
    chk("len0 valid_cycles", nv, 0);
    chk("len0 ram_reads", nr, 0);
    chk("len0 extra_done", nd, 0);
    chk("len0 issued_count_held", int'(issued_count), 1024);

    // Spurious access_done in IDLE, then a second start while busy.
    cif.access_done = 1'b1;
    @(posedge clk); #1;
    cif.access_done = 1'b0;
    chk("perr set", int'(protocol_err), 1);
    pv = '{2, 4, 4, 0, 5, 1, 15, 2, 0, 1};
    run(2, 4, 4, 0, 3, 0);
    check_run("restart_ignored", pv);
    chk("perr sticky", int'(protocol_err), 1);

    // Reset in the middle of entry 2's WAIT, then a fresh replay.
    run(4, 10, 10, 0, 0, 3);
    chk("abort reached", r_timeout, 0);
    @(posedge clk); #1;
    chk("midreset busy", int'(busy), 0);
    chk("midreset trace_valid", int'(cif.trace_valid), 0);
    chk("midreset issued_count", int'(issued_count), 0);
    chk("midreset ram_addr", int'(ram_addr), 0);
    chk("midreset protocol_err", int'(protocol_err), 0);
    chk("midreset done", int'(done), 0);
    reset = 1'b0;
    run(tbl[0].len, tbl[0].lat0, tbl[0].lat, tbl[0].rdy_hold, 0, 0);
    check_run("replay", tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
